// File: rtl/upsizer.sv
// Width upsizer: packs RATIO narrow valid/ready beats into one registered wide word.
// Optional UPSIZER_FLUSH_EN adds in_last / out_beats for early-terminated short words.
module upsizer #(
  parameter int unsigned IN_W  = 256,
  parameter int unsigned RATIO = 4,
  parameter int unsigned OUT_W = IN_W * RATIO
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [IN_W-1:0]       inp_data,
  input  logic                  valid_in,
  output logic                  in_ready,
  output logic [OUT_W-1:0]      data_out,
  output logic                  out_en,
  input  logic                  out_ready
`ifdef UPSIZER_FLUSH_EN
  ,
  input  logic                  in_last,
  output logic [$clog2(RATIO):0] out_beats
`endif
);

  localparam int unsigned CNT_W     = $clog2(RATIO);
  localparam int unsigned ACC_W     = (RATIO - 1) * IN_W;
  localparam int unsigned LAST_BEAT = RATIO - 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             out_en_q, out_en_d;
  logic             last_c;
  logic             final_c;
  logic             accept_c;

`ifdef UPSIZER_FLUSH_EN
  localparam int unsigned BEATS_W = CNT_W + 1;
  logic [BEATS_W-1:0] beats_q, beats_d;
  assign last_c = in_last;
`else
  assign last_c = 1'b0;
`endif

  // Only a word-completing beat can stall, and only while the previous word is still held.
  assign final_c  = (cnt_q == CNT_W'(LAST_BEAT)) | last_c;
  assign in_ready = ~final_c | ~out_en_q | out_ready;
  assign accept_c = valid_in & in_ready;

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    data_d   = data_q;
    out_en_d = out_en_q;
`ifdef UPSIZER_FLUSH_EN
    beats_d  = beats_q;
`endif
    if (out_en_q && out_ready) begin
      out_en_d = 1'b0;
    end
    if (accept_c) begin
      if (final_c) begin
        // Slices below the current beat come from acc; slices above it are zero-filled.
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          if (CNT_W'(k) < cnt_q) begin
            data_d[k*IN_W +: IN_W] = acc_q[k*IN_W +: IN_W];
          end else if (CNT_W'(k) == cnt_q) begin
            data_d[k*IN_W +: IN_W] = inp_data;
          end else begin
            data_d[k*IN_W +: IN_W] = '0;
          end
        end
        data_d[LAST_BEAT*IN_W +: IN_W] = (cnt_q == CNT_W'(LAST_BEAT)) ? inp_data : '0;
        out_en_d = 1'b1;
        cnt_d    = '0;
`ifdef UPSIZER_FLUSH_EN
        beats_d  = BEATS_W'(cnt_q) + BEATS_W'(1);
`endif
      end else begin
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          if (CNT_W'(k) == cnt_q) begin
            acc_d[k*IN_W +: IN_W] = inp_data;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      out_en_q <= 1'b0;
`ifdef UPSIZER_FLUSH_EN
      beats_q  <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      out_en_q <= out_en_d;
`ifdef UPSIZER_FLUSH_EN
      beats_q  <= beats_d;
`endif
    end
  end

  assign data_out = data_q;
  assign out_en   = out_en_q;
`ifdef UPSIZER_FLUSH_EN
  assign out_beats = beats_q;
`endif

endmodule

// File: tb/tb_upsizer.sv
// Directed bench for upsizer (4 x 256 -> 1024); flush cases run when UPSIZER_FLUSH_EN is defined.
module tb_upsizer;

  localparam int unsigned IN_W  = 256;
  localparam int unsigned RATIO = 4;
  localparam int unsigned OUT_W = IN_W * RATIO;

  logic             clk;
  logic             rstn;
  logic [IN_W-1:0]  inp_data;
  logic             valid_in;
  logic             in_ready;
  logic [OUT_W-1:0] data_out;
  logic             out_en;
  logic             out_ready;
`ifdef UPSIZER_FLUSH_EN
  logic             in_last;
  logic [2:0]       out_beats;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  upsizer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .inp_data  (inp_data),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_en    (out_en),
    .out_ready (out_ready)
`ifdef UPSIZER_FLUSH_EN
    ,
    .in_last   (in_last),
    .out_beats (out_beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IN_W-1:0] beat(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic check(input string tag, input logic [IN_W-1:0] got, input logic [IN_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare all four slices of data_out against expected beat bytes (b0 least significant).
  task automatic check_word(input string tag, input logic [7:0] b3, input logic [7:0] b2,
                            input logic [7:0] b1, input logic [7:0] b0);
    logic [7:0] bytes [RATIO];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    for (int k = 0; k < RATIO; k++)
      check($sformatf("%s[%0d]", tag, k), data_out[k*IN_W +: IN_W], beat(bytes[k]));
  endtask

  // Present one beat for one cycle, checking in_ready just before the edge.
  task automatic send(input logic [7:0] b, input logic exp_rdy);
    valid_in = 1'b1;
    inp_data = beat(b);
    #1;
    check($sformatf("in_ready@%h", b), IN_W'(in_ready), IN_W'(exp_rdy));
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle_cycle();
    valid_in = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] vpat;
    logic [7:0] cb [RATIO];
    int idx;

    rstn      = 1'b0;
    valid_in  = 1'b0;
    inp_data  = '0;
    out_ready = 1'b1;
`ifdef UPSIZER_FLUSH_EN
    in_last   = 1'b0;
`endif
    #12;
    check("rst_out_en", IN_W'(out_en), IN_W'(1'b0));
    check("rst_in_ready", IN_W'(in_ready), IN_W'(1'b1));
    check_word("rst_data", 8'h00, 8'h00, 8'h00, 8'h00);
`ifdef UPSIZER_FLUSH_EN
    check("rst_out_beats", IN_W'(out_beats), IN_W'(3'd0));
`endif
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic word A0..A3 back-to-back.
    send(8'h11, 1'b1);
    check("a_no_early", IN_W'(out_en), IN_W'(1'b0));
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    check("a_out_en", IN_W'(out_en), IN_W'(1'b1));
    check_word("a_word", 8'h44, 8'h33, 8'h22, 8'h11);
    idle_cycle();
    check("a_out_en_1cyc", IN_W'(out_en), IN_W'(1'b0));

    // Eight consecutive beats -> two words, no stall.
    for (int i = 0; i < 8; i++) begin
      send(8'h51 + 8'(i), 1'b1);
      valid_in = 1'b1;
      check($sformatf("s_out_en%0d", i), IN_W'(out_en), IN_W'(i == 3 || i == 7));
      if (i == 3) check_word("s_word1", 8'h54, 8'h53, 8'h52, 8'h51);
      if (i == 7) check_word("s_word2", 8'h58, 8'h57, 8'h56, 8'h55);
    end
    idle_cycle();
    check("s_drain", IN_W'(out_en), IN_W'(1'b0));

    // Backpressure: word held, final beat stalls, then transfer+accept in one cycle.
    out_ready = 1'b0;
    send(8'h61, 1'b1);
    send(8'h62, 1'b1);
    send(8'h63, 1'b1);
    send(8'h64, 1'b1);
    send(8'h71, 1'b1);
    send(8'h72, 1'b1);
    send(8'h73, 1'b1);
    check("bp_held_en", IN_W'(out_en), IN_W'(1'b1));
    check_word("bp_held", 8'h64, 8'h63, 8'h62, 8'h61);
    valid_in = 1'b1;
    inp_data = beat(8'h74);
    #1;
    check("bp_stall_rdy", IN_W'(in_ready), IN_W'(1'b0));
    @(posedge clk); #1;
    check("bp_stall_rdy2", IN_W'(in_ready), IN_W'(1'b0));
    check_word("bp_still", 8'h64, 8'h63, 8'h62, 8'h61);
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", IN_W'(in_ready), IN_W'(1'b1));
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("bp_no_bubble", IN_W'(out_en), IN_W'(1'b1));
    check_word("bp_word2", 8'h74, 8'h73, 8'h72, 8'h71);
    idle_cycle();
    check("bp_drain", IN_W'(out_en), IN_W'(1'b0));

    // Gappy valid_in (1,0,0,1,0,1,1) over C0..C3, output held with out_ready=0.
    out_ready = 1'b0;
    vpat = 7'b1101001;
    cb[0] = 8'h81; cb[1] = 8'h82; cb[2] = 8'h83; cb[3] = 8'h84;
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      valid_in = vpat[i];
      inp_data = beat(cb[idx]);
      @(posedge clk); #1;
      if (vpat[i]) idx++;
      check($sformatf("g_out_en%0d", i), IN_W'(out_en), IN_W'(i == 6));
    end
    valid_in = 1'b0;
    check_word("g_word", 8'h84, 8'h83, 8'h82, 8'h81);

    // Two beats of a partial word, then async reset while C is still pending.
    send(8'h91, 1'b1);
    send(8'h92, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("r_out_en", IN_W'(out_en), IN_W'(1'b0));
    check("r_in_ready", IN_W'(in_ready), IN_W'(1'b1));
    check_word("r_data", 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(8'hA1, 1'b1);
    send(8'hA2, 1'b1);
    send(8'hA3, 1'b1);
    check("r_no_residue", IN_W'(out_en), IN_W'(1'b0));
    send(8'hA4, 1'b1);
    check("r_d_en", IN_W'(out_en), IN_W'(1'b1));
    check_word("r_d_word", 8'hA4, 8'hA3, 8'hA2, 8'hA1);
    idle_cycle();
    check("r_drain", IN_W'(out_en), IN_W'(1'b0));

`ifdef UPSIZER_FLUSH_EN
    // Short word E0,E1 terminated by in_last, then a full word.
    send(8'hB1, 1'b1);
    in_last = 1'b1;
    send(8'hB2, 1'b1);
    in_last = 1'b0;
    check("f_short_en", IN_W'(out_en), IN_W'(1'b1));
    check_word("f_short", 8'h00, 8'h00, 8'hB2, 8'hB1);
    check("f_short_beats", IN_W'(out_beats), IN_W'(3'd2));
    send(8'hC1, 1'b1);
    send(8'hC2, 1'b1);
    send(8'hC3, 1'b1);
    send(8'hC4, 1'b1);
    check("f_full_en", IN_W'(out_en), IN_W'(1'b1));
    check_word("f_full", 8'hC4, 8'hC3, 8'hC2, 8'hC1);
    check("f_full_beats", IN_W'(out_beats), IN_W'(3'd4));
    idle_cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
